// File: rtl/bram_ctrl_pkg.sv
// Shared types and helpers for the bram_ctrl block RAM controller.
// Holds the controller state encoding, the latency ceiling and the byte-mask helper.
package bram_ctrl_pkg;

    typedef enum logic {
        BRAM_CLEAR = 1'b0,
        BRAM_IDLE  = 1'b1
    } bram_state_e;

    localparam int unsigned MaxReadLatency = 4;

    // One byte enable bit becomes eight mask bits; callers apply it per byte lane.
    function automatic logic [7:0] bram_be_mask(input logic be);
        return {8{be}};
    endfunction

endpackage

// File: rtl/bram_ctrl_chk.sv
// Out-of-bounds access checker for bram_ctrl, present only with BRAM_CTRL_OOB_CHECK_EN.
`ifdef BRAM_CTRL_OOB_CHECK_EN
module bram_ctrl_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic oob_acc_i
);

    a_no_oob_access: assert property (@(posedge clk_i) disable iff (!rst_ni) !oob_acc_i)
        else $error("bram_ctrl: accepted access with address beyond Depth");

endmodule
`endif

// File: rtl/bram_read_pipe.sv
// Delay line for read data and its valid strobe behind the memory output register.
// Data stages only load when their input is valid, so the output holds the last completed read.
module bram_read_pipe #(
    parameter int unsigned Width  = 8,
    parameter int unsigned Stages = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_c [Stages+1];
    logic [Width-1:0] data_c  [Stages+1];

    assign valid_c[0] = valid_i;
    assign data_c[0]  = data_i;

    for (genvar g = 0; g < Stages; g++) begin : g_stage
        logic             valid_q;
        logic             valid_d;
        logic [Width-1:0] data_q;
        logic [Width-1:0] data_d;

        // Next value of this stage: advance on valid, otherwise hold the data.
        always_comb begin
            valid_d = valid_c[g];
            if (valid_c[g]) begin
                data_d = data_c[g];
            end else begin
                data_d = data_q;
            end
        end

        // Stage register; valid bits flush on reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                data_q  <= {Width{1'b0}};
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign valid_c[g+1] = valid_q;
        assign data_c[g+1]  = data_q;
    end

    assign valid_o = valid_c[Stages];
    assign data_o  = data_c[Stages];

endmodule

// File: rtl/bram_ctrl.sv
// Single-port block RAM with req/ready handshake, byte enables, valid-qualified reads and a clear engine.
// Optional feature macro: BRAM_CTRL_OOB_CHECK_EN (address range check, sticky err_o, assertion).
module bram_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned Depth       = 1024,
    parameter int unsigned ReadLatency = 1,
    parameter int unsigned AddrWidth   = $clog2(Depth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   req_i,
    output logic                   ready_o,
    input  logic                   write_en_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   data_i,
    output logic [DataWidth-1:0]   data_o,
    output logic                   valid_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int unsigned NumBytes   = DataWidth / 8;
    localparam int unsigned EffLatency = (ReadLatency < 1) ? 1 :
                                         ((ReadLatency > MaxReadLatency) ? MaxReadLatency : ReadLatency);
    localparam int unsigned PipeStages = EffLatency - 1;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

    bram_state_e            state_q, state_d;
    logic [AddrWidth-1:0]   cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [DataWidth-1:0]   rd_data_q, rd_data_d;

    logic [DataWidth-1:0]   mem [Depth];
    logic                   mem_we;
    logic [AddrWidth-1:0]   mem_addr;
    logic [DataWidth-1:0]   mem_wdata;
    logic [DataWidth-1:0]   mem_mask;
    logic [DataWidth-1:0]   be_mask;

    logic                   oob;
    logic                   accept;
    logic                   rd_accept;
    logic                   wr_accept;

    for (genvar n = 0; n < NumBytes; n++) begin : g_be_mask
        assign be_mask[8*n +: 8] = bram_be_mask(be_i[n]);
    end

`ifdef BRAM_CTRL_OOB_CHECK_EN
    localparam logic [AddrWidth:0] DepthExt = (AddrWidth + 1)'(Depth);
    assign oob = ({1'b0, addr_i} >= DepthExt);
`else
    assign oob = 1'b0;
`endif

    // ready_q is high exactly in IDLE, so acceptance never happens during a clear.
    assign accept    = req_i && ready_q;
    assign rd_accept = accept && !write_en_i;
    assign wr_accept = accept && write_en_i && !oob;

    // Next-state logic and memory write port arbitration between clear engine and requests.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_addr  = addr_i;
        mem_wdata = data_i;
        mem_mask  = be_mask;
        case (state_q)
            BRAM_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = {DataWidth{1'b0}};
                mem_mask  = {DataWidth{1'b1}};
                if (cnt_q == LastAddr) begin
                    state_d = BRAM_IDLE;
                    cnt_d   = {AddrWidth{1'b0}};
                end else begin
                    state_d = BRAM_CLEAR;
                    cnt_d   = cnt_q + AddrWidth'(1'b1);
                end
            end
            BRAM_IDLE: begin
                mem_we = wr_accept;
                if (clear_i) begin
                    state_d = BRAM_CLEAR;
                    cnt_d   = {AddrWidth{1'b0}};
                end else begin
                    state_d = BRAM_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = BRAM_CLEAR;
                cnt_d   = {AddrWidth{1'b0}};
            end
        endcase
        ready_d = (state_d == BRAM_IDLE);
        busy_d  = (state_d == BRAM_CLEAR);
    end

    // First read stage: capture memory output on an accepted read, otherwise hold.
    always_comb begin
        rd_valid_d = rd_accept;
        if (rd_accept) begin
            if (oob) begin
                rd_data_d = {DataWidth{1'b0}};
            end else begin
                rd_data_d = mem[addr_i];
            end
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Control and first read stage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= BRAM_CLEAR;
            cnt_q      <= {AddrWidth{1'b0}};
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DataWidth{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Memory array; contents are only defined once a clear has swept it.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_addr] <= (mem[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
        end
    end

    bram_read_pipe #(
        .Width  (DataWidth),
        .Stages (PipeStages)
    ) u_read_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (rd_valid_q),
        .data_i  (rd_data_q),
        .valid_o (valid_o),
        .data_o  (data_o)
    );

`ifdef BRAM_CTRL_OOB_CHECK_EN
    logic err_q, err_d;

    // Sticky range error, released when the next clear finishes.
    always_comb begin
        if (accept && oob) begin
            err_d = 1'b1;
        end else if ((state_q == BRAM_CLEAR) && (cnt_q == LastAddr)) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

    bram_ctrl_chk u_chk (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .oob_acc_i (accept && oob)
    );
`else
    assign err_o = 1'b0;
`endif

    assign ready_o = ready_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_bram_ctrl.sv
// Directed, table-driven bench for bram_ctrl (32-bit words, read latency 3).
module tb_bram_ctrl;

`ifdef BRAM_CTRL_OOB_CHECK_EN
    localparam int DEPTH = 10;
`else
    localparam int DEPTH = 16;
`endif
    localparam int RL = 3;

    logic        clk_i      = 1'b0;
    logic        rst_ni     = 1'b1;
    logic        clear_i    = 1'b0;
    logic        req_i      = 1'b0;
    logic        write_en_i = 1'b0;
    logic [3:0]  be_i       = 4'h0;
    logic [3:0]  addr_i     = 4'h0;
    logic [31:0] data_i     = 32'h0;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        busy_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    bram_ctrl #(
        .DataWidth   (32),
        .Depth       (DEPTH),
        .ReadLatency (RL)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .req_i      (req_i),
        .ready_o    (ready_o),
        .write_en_i (write_en_i),
        .be_i       (be_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        req_i = 1'b1; write_en_i = 1'b1; addr_i = a; data_i = d; be_i = be;
        step();
        req_i = 1'b0; write_en_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        int lat;
        int pulses;
        logic [31:0] got;
        lat = 0; pulses = 0; got = 32'h0;
        req_i = 1'b1; write_en_i = 1'b0; addr_i = a;
        for (int k = 1; k <= RL + 3; k++) begin
            step();
            if (k == 1) req_i = 1'b0;
            if (valid_o === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    got = data_o;
                end
            end
        end
        check("rd_latency", lat, RL);
        check("rd_data", got, exp);
        check("rd_pulses", pulses, 1);
        check("rd_hold", data_o, exp);
    endtask

    task automatic rst_clear();
        int n;
        int seen;
        rst_ni = 1'b0; req_i = 1'b0; clear_i = 1'b0;
        #1;
        check("rst_ready", ready_o, 0);
        check("rst_busy", busy_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_err", err_o, 0);
        step();
        step();
        rst_ni = 1'b1;
        n = 0; seen = 0;
        while (busy_o === 1'b1 && n < 200) begin
            if (valid_o === 1'b1) seen++;
            step();
            n++;
        end
        check("clear_cycles", n, DEPTH);
        check("ready_after_clear", ready_o, 1);
        check("busy_after_clear", busy_o, 0);
        check("no_valid_after_rst", seen, 0);
    endtask

    initial begin
        int nvalid;
        int low;
        int v1k;
        int v2k;
        logic [31:0] v1d;
        logic [31:0] v2d;

        vecs[0]  = '{1'b1, 4'hF, 4'd3, 32'h0000_00A5, 32'h0};
        vecs[1]  = '{1'b0, 4'h0, 4'd3, 32'h0,         32'h0000_00A5};
        vecs[2]  = '{1'b1, 4'hF, 4'd5, 32'h1122_3344, 32'h0};
        vecs[3]  = '{1'b1, 4'h5, 4'd5, 32'hFFFF_FFFF, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 4'd5, 32'h0,         32'h11FF_33FF};
        vecs[5]  = '{1'b1, 4'h0, 4'd7, 32'hDEAD_BEEF, 32'h0};
        vecs[6]  = '{1'b0, 4'h0, 4'd7, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 4'hA, 4'd0, 32'hCAFE_F00D, 32'h0};
        vecs[8]  = '{1'b0, 4'h0, 4'd0, 32'h0,         32'hCA00_F000};
        vecs[9]  = '{1'b1, 4'hC, 4'd9, 32'h1234_5678, 32'h0};
        vecs[10] = '{1'b0, 4'h0, 4'd9, 32'h0,         32'h1234_0000};
        vecs[11] = '{1'b1, 4'hF, 4'd1, 32'h0000_0007, 32'h0};
        vecs[12] = '{1'b1, 4'hF, 4'd2, 32'h0000_0009, 32'h0};
        vecs[13] = '{1'b0, 4'h0, 4'd1, 32'h0,         32'h0000_0007};
        vecs[14] = '{1'b0, 4'h0, 4'd2, 32'h0,         32'h0000_0009};

        #2;
        rst_clear();
        for (int a = 0; a < DEPTH; a++) rd(4'(a), 32'h0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            else            rd(vecs[i].addr, vecs[i].exp);
        end

        // Two back-to-back reads, the second alongside clear_i; a dropped write and an ignored clear_i during CLEAR.
        nvalid = 0; low = 0; v1k = 0; v2k = 0; v1d = 32'h0; v2d = 32'h0;
        req_i = 1'b1; write_en_i = 1'b0; addr_i = 4'd1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (valid_o === 1'b1) begin
                nvalid++;
                if (nvalid == 1) begin v1k = k; v1d = data_o; end
                if (nvalid == 2) begin v2k = k; v2d = data_o; end
            end
            if (ready_o === 1'b0) low++;
            case (k)
                1: begin addr_i = 4'd2; clear_i = 1'b1; end
                2: begin req_i = 1'b0; clear_i = 1'b0; end
                5: begin req_i = 1'b1; write_en_i = 1'b1; addr_i = 4'd0; data_i = 32'h66; be_i = 4'hF; end
                7: begin req_i = 1'b0; write_en_i = 1'b0; end
                8: clear_i = 1'b1;
                9: clear_i = 1'b0;
                default: ;
            endcase
        end
        check("inflight_count", nvalid, 2);
        check("inflight1_cycle", v1k, RL);
        check("inflight1_data", v1d, 32'h7);
        check("inflight2_cycle", v2k, RL + 1);
        check("inflight2_data", v2d, 32'h9);
        check("clear_ready_low", low, DEPTH);
        rd(4'd0, 32'h0);
        rd(4'd1, 32'h0);
        rd(4'd2, 32'h0);

        // Reset with a read in flight and a clear just started.
        req_i = 1'b1; write_en_i = 1'b0; addr_i = 4'd3; clear_i = 1'b1;
        step();
        req_i = 1'b0; clear_i = 1'b0;
        step();
        rst_clear();

        // Reset in the middle of a clear at cnt = 5.
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        repeat (5) step();
        rst_clear();

`ifdef BRAM_CTRL_OOB_CHECK_EN
        wr(4'd12, 32'hFFFF_FFFF, 4'hF);
        check("oob_err_set", err_o, 1);
        rd(4'd12, 32'h0);
        check("oob_err_sticky", err_o, 1);
        rd(4'd2, 32'h0);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        for (int n = 0; n < 200 && busy_o === 1'b1; n++) step();
        check("oob_err_cleared", err_o, 0);
        check("oob_ready", ready_o, 1);
`else
        check("err_tied_low", err_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_ctrl.md
Name: bram_ctrl

Overview:
- Next-generation parametrised single-port block RAM with a request/ready handshake, per-byte write enables, configurable read latency with a valid strobe, and a hardware clear engine.
- The clear engine zeroes memory after reset or on command.
- Used by the MNIST datapath for weight, activation and scratch buffers where the consumer needs a valid-qualified read stream, not a fixed one-cycle contract.

Parameters:
- DataWidth, 8, word width in bits; must be a multiple of 8.
- Depth, 1024, number of words; any value ≥ 2, not necessarily a power of two.
- ReadLatency, 1, cycles from accepted read to data_o/valid_o; range 1..4.
- AddrWidth, $clog2(Depth), address width (derived; do not override).

Ports:
- clk_i  input  1  single clock, all logic on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- clear_i  input  1  one-cycle pulse; starts a full memory clear when idle.
- req_i  input  1  access request; accepted when req_i && ready_o.
- ready_o  output  1  high when the block accepts a request (state IDLE).
- write_en_i  input  1  1 = write, 0 = read; sampled with req_i.
- be_i  input  DataWidth/8  byte enables for writes; bit n covers data bits [8n+7:8n].
- addr_i  input  AddrWidth  word address.
- data_i  input  DataWidth  write data.
- data_o  output  DataWidth  read data; holds its last value until the next read completes.
- valid_o  output  1  one-cycle pulse when data_o carries a completed read.
- busy_o  output  1  high while the clear engine runs.
- err_o  output  1  out-of-bounds flag (see Optional Feature).

Behaviour:
- Reset values:
  - ready_o = 0, busy_o = 1, valid_o = 0, data_o = 0, err_o = 0.
  - FSM = CLEAR, clear counter = 0.
  - Read pipeline valid bits = 0.
  - Memory array itself is not async-reset.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes all-zero to memory[cnt], then cnt++. When cnt == Depth-1 is written, go to IDLE next cycle. Clearing takes exactly Depth cycles.
  - IDLE: ready_o = 1, busy_o = 0. clear_i = 1 moves to CLEAR with cnt = 0; ready_o drops the following cycle.
  - clear_i is ignored while in CLEAR; no restart and no extension.
  - A request in the same cycle as clear_i in IDLE is accepted and executed; the clear starts after it.
- Handshake:
  - Requests with ready_o = 0 are dropped without effect; the requester must hold them.
  - One access per cycle; back-to-back reads give one valid_o per cycle.
- Write: memory[addr_i] updated only for bytes with be_i[n] = 1. be_i = 0 is a legal no-op. No valid_o for writes.
- Read:
  - Memory output registered at stage 1, then ReadLatency-1 extra register stages.
  - An accepted read at cycle t gives valid_o = 1 and data_o at cycle t+ReadLatency.
- Read-after-write:
  - Same address in consecutive cycles: the read sees the new data.
  - A single access is never both a read and a write.
- Clear vs in-flight reads: reads already in the pipeline when CLEAR begins still complete with their pre-clear data.
- Reset mid-operation:
  - Pipeline valid bits are flushed, so no valid_o after reset.
  - The clear restarts from 0; memory contents are undefined until the clear completes.

Optional Feature:
- Macro: BRAM_CTRL_OOB_CHECK_EN.
- With the macro:
  - An accepted request with addr_i ≥ Depth suppresses the write.
  - A read returns data_o = 0 with valid_o still pulsed at normal latency.
  - err_o is sticky high from the cycle after acceptance until the next clear completes or reset.
  - A simulation assertion fires on every such access.
- Without the macro: err_o is tied 0, no check logic exists, and out-of-range access behaviour is undefined.

Decomposition:
- Package bram_ctrl_pkg:
  - typedef enum logic bram_state_e {BRAM_CLEAR, BRAM_IDLE}.
  - localparam MaxReadLatency = 4.
  - function bram_be_mask(be) that expands byte enables to a bit mask.
- Sub-module bram_read_pipe: parametrised delay line for data and valid, depth ReadLatency-1, async-reset valid bits. It is instantiated after the memory output register.

Test Plan:
- Reset release, Depth=16 -> busy_o high for exactly 16 cycles, then ready_o = 1; a read of every address returns 0x00.
- Write 0xA5 to addr 3, then read addr 3 with ReadLatency=3 -> valid_o pulses exactly 3 cycles after read acceptance, data_o = 0xA5.
- DataWidth=32: write 0x11223344, then write 0xFFFFFFFF with be_i = 4'b0101 -> read returns 0x11FF33FF.
- Pulse clear_i while reads to addrs 1 and 2 (holding 0x7, 0x9) are in flight -> both valid_o with 0x7, 0x9; ready_o low for 16 cycles; a later read returns 0.
- Assert rst_ni low during a clear at cnt = 5 and during a pending read -> no valid_o after release; full 16-cycle clear reruns.
- With BRAM_CTRL_OOB_CHECK_EN, Depth=10: write addr 12 -> err_o = 1 next cycle, no memory change; read addr 12 -> data_o = 0 with valid_o; clear_i completes -> err_o = 0.
